// File: rtl/int_request_ctrl_pkg.sv
// int_request_ctrl_pkg: shared state encodings, ids and priority helper for the interrupt request controller
package int_request_ctrl_pkg;
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ASSERT   = 2'd1,
        S_WAIT_ACK = 2'd2
    } state_e;
    localparam logic [3:0] ERET_ID     = 4'hF;
    localparam logic [3:0] ECAUSE_HARD = 4'h0;
    localparam logic [3:0] ECAUSE_SOFT = 4'h1;
    localparam logic [3:0] ECAUSE_ERET = 4'h2;
    function automatic logic [2:0] prio_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = 7; i >= 0; i--)
            if (v[i]) idx = 3'(i);
        return idx;
    endfunction
endpackage

// File: rtl/int_request_ctrl_irq_sync_edge.sv
// irq_sync_edge: two-flop synchroniser with falling-edge detect for one active-low line
module irq_sync_edge (
    input  logic ici_clk,
    input  logic ici_rst,
    input  logic irq_n,
    output logic fall
);
    logic s1_q, s2_q, s2_prev_q;
    always_ff @(posedge ici_clk) begin
        if (ici_rst) begin
            s1_q      <= 1'b1;
            s2_q      <= 1'b1;
            s2_prev_q <= 1'b1;
        end else begin
            s1_q      <= irq_n;
            s2_q      <= s1_q;
            s2_prev_q <= s2_q;
        end
    end
    assign fall = s2_prev_q & ~s2_q;
endmodule

// File: rtl/int_request_ctrl.sv
// int_request_ctrl: latches external interrupt edges, issues one hard pulse at a time and forwards soft requests
module int_request_ctrl
    import int_request_ctrl_pkg::*;
#(
    parameter int N_SRC     = 4,
    parameter int PULSE_LEN = 2,
    parameter int ACK_TMO   = 15
) (
    input  logic             ici_clk,
    input  logic             ici_rst,
    input  logic [N_SRC-1:0] ici_irq,
    input  logic             ici_int_en,
    input  logic             ici_mask_we,
    input  logic [N_SRC-1:0] ici_mask_wdata,
    input  logic             ici_soft_req,
    input  logic [3:0]       ici_soft_id,
    input  logic             ici_ack,
    output logic             ico_hard_int,
    output logic [2:0]       ico_hard_src,
    output logic             ico_int,
    output logic [3:0]       ico_int_id,
    output logic [N_SRC-1:0] ico_pending,
    output logic [N_SRC-1:0] ico_mask
);
    state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] src_q, src_d;
    logic [N_SRC-1:0] pend_q, pend_d, mask_q, mask_d, fall, elig, clr;
    logic int_q, int_d;
    logic [3:0] int_id_q, int_id_d;
    for (genvar g = 0; g < N_SRC; g++) begin : g_sync
        irq_sync_edge u_sync (
            .ici_clk (ici_clk),
            .ici_rst (ici_rst),
            .irq_n   (ici_irq[g]),
            .fall    (fall[g])
        );
    end
    always_ff @(posedge ici_clk) begin
        if (ici_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            src_q    <= '0;
            pend_q   <= '0;
            mask_q   <= '1;
            int_q    <= 1'b0;
            int_id_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            src_q    <= src_d;
            pend_q   <= pend_d;
            mask_q   <= mask_d;
            int_q    <= int_d;
            int_id_q <= int_id_d;
        end
    end
    always_comb begin
        elig     = pend_q & mask_q & {N_SRC{ici_int_en}};
        state_d  = state_q;
        cnt_d    = cnt_q;
        src_d    = src_q;
        clr      = '0;
        unique case (state_q)
            S_IDLE:
                if (|elig && !int_q) begin
                    state_d = S_ASSERT;
                    cnt_d   = 4'(PULSE_LEN - 1);
                    src_d   = prio_idx(8'(elig));
                end
            S_ASSERT:
                if (cnt_q == '0) begin
                    state_d = S_WAIT_ACK;
                    cnt_d   = '0;
                end else cnt_d = cnt_q - 4'd1;
            S_WAIT_ACK:
                // an ack while a soft request is in flight belongs to the soft path
                if (ici_ack && !int_q) begin
                    clr     = N_SRC'(1) << src_q;
                    state_d = S_IDLE;
                end else if (cnt_q == 4'(ACK_TMO)) state_d = S_IDLE;
                else cnt_d = cnt_q + 4'd1;
            default: state_d = S_IDLE;
        endcase
        pend_d   = (pend_q & ~clr) | fall;
        mask_d   = ici_mask_we ? ici_mask_wdata : mask_q;
        int_d    = ici_soft_req;
        int_id_d = ici_soft_id;
    end
    always_comb begin
        ico_hard_int = state_q == S_ASSERT;
        ico_hard_src = src_q;
        ico_int      = int_q;
        ico_int_id   = int_id_q;
        ico_pending  = pend_q;
        ico_mask     = mask_q;
    end
endmodule

// File: tb/tb_int_request_ctrl.sv
// tb_int_request_ctrl: directed self-checking bench for int_request_ctrl
module tb_int_request_ctrl;
    logic       clk = 1'b0, rst = 1'b1;
    logic [3:0] irq = 4'hF;
    logic       int_en = 1'b1, mask_we = 1'b0, soft_req = 1'b0, ack = 1'b0;
    logic [3:0] mask_wdata = 4'hF, soft_id = 4'h0;
    logic       hard_int, int_o;
    logic [2:0] hard_src;
    logic [3:0] int_id, pending, mask;
    int checks = 0, failures = 0;

    int_request_ctrl dut (
        .ici_clk        (clk),
        .ici_rst        (rst),
        .ici_irq        (irq),
        .ici_int_en     (int_en),
        .ici_mask_we    (mask_we),
        .ici_mask_wdata (mask_wdata),
        .ici_soft_req   (soft_req),
        .ici_soft_id    (soft_id),
        .ici_ack        (ack),
        .ico_hard_int   (hard_int),
        .ico_hard_src   (hard_src),
        .ico_int        (int_o),
        .ico_int_id     (int_id),
        .ico_pending    (pending),
        .ico_mask       (mask)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset
        tick(2);
        chk("rst_hard_int", 32'(hard_int), 0);
        chk("rst_src", 32'(hard_src), 0);
        chk("rst_int", 32'(int_o), 0);
        chk("rst_int_id", 32'(int_id), 0);
        chk("rst_pend", 32'(pending), 0);
        chk("rst_mask", 32'(mask), 32'hF);
        rst = 1'b0;
        // single source irq[2]
        irq[2] = 1'b0;
        tick(2);
        chk("t2_pend_early", 32'(pending), 0);
        tick();
        chk("t2_pend", 32'(pending), 32'h4);
        chk("t2_no_pulse_yet", 32'(hard_int), 0);
        tick();
        chk("t2_pulse1", 32'(hard_int), 1);
        chk("t2_src", 32'(hard_src), 2);
        tick();
        chk("t2_pulse2", 32'(hard_int), 1);
        tick();
        chk("t2_pulse_end", 32'(hard_int), 0);
        irq[2] = 1'b1;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("t2_retired", 32'(pending), 0);
        // simultaneous irq[3] and irq[1]
        irq = 4'b0101;
        tick(3);
        chk("t3_pend", 32'(pending), 32'hA);
        tick();
        chk("t3_first_pulse", 32'(hard_int), 1);
        chk("t3_first_src", 32'(hard_src), 1);
        tick(2);
        chk("t3_first_end", 32'(hard_int), 0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("t3_pend_after_ack1", 32'(pending), 32'h8);
        tick();
        chk("t3_second_pulse", 32'(hard_int), 1);
        chk("t3_second_src", 32'(hard_src), 3);
        tick(2);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        irq = 4'hF;
        chk("t3_retired", 32'(pending), 0);
        // masked source held pending, then released
        mask_we = 1'b1;
        mask_wdata = 4'b1110;
        tick();
        mask_we = 1'b0;
        chk("t4_mask", 32'(mask), 32'hE);
        irq[0] = 1'b0;
        tick(3);
        chk("t4_pend", 32'(pending), 32'h1);
        tick(2);
        chk("t4_masked_no_pulse", 32'(hard_int), 0);
        mask_we = 1'b1;
        mask_wdata = 4'hF;
        tick();
        mask_we = 1'b0;
        chk("t4_mask_restored", 32'(mask), 32'hF);
        chk("t4_no_pulse_yet", 32'(hard_int), 0);
        tick();
        chk("t4_pulse", 32'(hard_int), 1);
        chk("t4_src", 32'(hard_src), 0);
        tick(2);
        chk("t4_wait_ack", 32'(hard_int), 0);
        // ack timeout re-arms and re-issues
        tick(15);
        chk("t5_still_waiting", 32'(hard_int), 0);
        chk("t5_pend_held", 32'(pending), 32'h1);
        tick();
        chk("t5_idle_no_pulse", 32'(hard_int), 0);
        tick();
        chk("t5_reissue", 32'(hard_int), 1);
        chk("t5_reissue_src", 32'(hard_src), 0);
        tick(2);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        irq[0] = 1'b1;
        chk("t5_retired", 32'(pending), 0);
        tick(3);
        // soft request defers hard pulse
        irq[0] = 1'b0;
        tick(2);
        soft_req = 1'b1;
        soft_id = 4'hF;
        tick();
        soft_req = 1'b0;
        chk("t6_pend", 32'(pending), 32'h1);
        chk("t6_int", 32'(int_o), 1);
        chk("t6_int_id", 32'(int_id), 32'hF);
        chk("t6_deferred", 32'(hard_int), 0);
        tick();
        chk("t6_int_drop", 32'(int_o), 0);
        chk("t6_still_deferred", 32'(hard_int), 0);
        tick();
        chk("t6_pulse", 32'(hard_int), 1);
        chk("t6_src", 32'(hard_src), 0);
        tick(2);
        soft_req = 1'b1;
        tick();
        soft_req = 1'b0;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("t6_soft_ack_keeps_pend", 32'(pending), 32'h1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        irq[0] = 1'b1;
        chk("t6_hard_ack_retires", 32'(pending), 0);
        tick(3);
        // reset in the middle of a pulse
        irq[1] = 1'b0;
        tick(4);
        chk("t7_pulse_before_rst", 32'(hard_int), 1);
        rst = 1'b1;
        irq[1] = 1'b1;
        tick();
        chk("t7_rst_drops_pulse", 32'(hard_int), 0);
        chk("t7_rst_pend", 32'(pending), 0);
        rst = 1'b0;
        tick(4);
        chk("t7_quiet_after_rst", 32'(pending), 0);
        chk("t7_no_pulse_after_rst", 32'(hard_int), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
